// File: rtl/nios_ii_base_mem_pkg.sv
// rtl/nios_ii_base_mem_pkg.sv - shared widths, depth and request record for the on-chip memory arbiter
package nios_ii_base_mem_pkg;
  localparam int MEM_ADDR_W = 15;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_BE_W   = 8;
  localparam int MEM_DEPTH  = 32000;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_BE_W-1:0]   be;
    logic                  rd;
    logic                  wr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/nios_ii_base_rr_arbiter.sv
// rtl/nios_ii_base_rr_arbiter.sv - round-robin grant, searching upward from the master after the last grant
module nios_ii_base_rr_arbiter
  import nios_ii_base_mem_pkg::*;
#(
  parameter  int N    = 2,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_i,
  input  logic            advance_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            gnt_valid_o
);
  logic [ID_W-1:0] last_grant_q, last_grant_d;

  always_comb begin
    gnt_o       = '0;
    gnt_id_o    = '0;
    gnt_valid_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((int'(last_grant_q) + k) % N);
      if (advance_i && !gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = idx;
        gnt_o[idx]  = 1'b1;
      end
    end
    last_grant_d = gnt_valid_o ? gnt_id_o : last_grant_q;
  end

  // Starting at N-1 makes master 0 the first in line after reset.
  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= ID_W'(N - 1);
    else       last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/nios_ii_base_onchip_mem_arbiter.sv
// rtl/nios_ii_base_onchip_mem_arbiter.sv - shares the single-port 64-bit on-chip memory between Avalon-MM masters
module nios_ii_base_onchip_mem_arbiter
  import nios_ii_base_mem_pkg::*;
#(
  parameter int NUM_MASTERS  = 2,
  parameter int MEM_DEPTH    = nios_ii_base_mem_pkg::MEM_DEPTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MEM_ADDR_W*NUM_MASTERS-1:0] m_address,
  input  logic [MEM_BE_W*NUM_MASTERS-1:0]   m_byteenable,
  input  logic [NUM_MASTERS-1:0]            m_read,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [MEM_DATA_W*NUM_MASTERS-1:0] m_writedata,
  output logic [NUM_MASTERS-1:0]            m_waitrequest,
  output logic [MEM_DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]            m_readdatavalid,
  input  logic                              freeze,
  output logic [MEM_ADDR_W-1:0]             mem_address,
  output logic [MEM_BE_W-1:0]               mem_byteenable,
  output logic                              mem_chipselect,
  output logic                              mem_write,
  output logic [MEM_DATA_W-1:0]             mem_writedata,
  output logic                              mem_clken,
  input  logic [MEM_DATA_W-1:0]             mem_readdata
);
  localparam int ID_W = $clog2(NUM_MASTERS);

  if (READ_LATENCY != 1) begin : g_bad_read_latency
    $error("READ_LATENCY must be 1");
  end
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
    $error("NUM_MASTERS must be 2..8");
  end

  logic [NUM_MASTERS-1:0] req, gnt;
  logic [ID_W-1:0]        gnt_id, sel_id;
  logic                   gnt_valid, in_range;
  mem_req_t               reqs [NUM_MASTERS];
  mem_req_t               sel_req;

  logic            rd_pend_valid_q, rd_pend_valid_d;
  logic [ID_W-1:0] rd_pend_id_q, rd_pend_id_d;
  logic            rd_pend_oor_q, rd_pend_oor_d;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign reqs[i] = '{addr:  m_address[i*MEM_ADDR_W +: MEM_ADDR_W],
                       be:    m_byteenable[i*MEM_BE_W +: MEM_BE_W],
                       rd:    m_read[i],
                       wr:    m_write[i],
                       wdata: m_writedata[i*MEM_DATA_W +: MEM_DATA_W]};
  end

  assign req = m_read | m_write;

  nios_ii_base_rr_arbiter #(.N(NUM_MASTERS)) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .advance_i   (~freeze & ~reset),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (gnt_valid)
  );

  assign sel_id   = gnt_valid ? gnt_id : '0;
  assign sel_req  = reqs[sel_id];
  assign in_range = 32'(sel_req.addr) < 32'(MEM_DEPTH);

  // Out-of-range accesses are still granted but never reach the memory.
  assign mem_address    = sel_req.addr;
  assign mem_byteenable = sel_req.be;
  assign mem_writedata  = sel_req.wdata;
  assign mem_chipselect = gnt_valid & in_range;
  assign mem_write      = gnt_valid & sel_req.wr & in_range;
  assign mem_clken      = ~freeze;

  assign m_waitrequest = reset ? '1 : (req & ~gnt);

  // A master asserting read and write together is treated as a write.
  assign rd_pend_valid_d = gnt_valid & sel_req.rd & ~sel_req.wr;
  assign rd_pend_id_d    = gnt_id;
  assign rd_pend_oor_d   = ~in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_valid_q <= 1'b0;
      rd_pend_id_q    <= '0;
      rd_pend_oor_q   <= 1'b0;
    end else begin
      rd_pend_valid_q <= rd_pend_valid_d;
      rd_pend_id_q    <= rd_pend_id_d;
      rd_pend_oor_q   <= rd_pend_oor_d;
    end
  end

  always_comb begin
    m_readdatavalid = '0;
    if (rd_pend_valid_q && !reset) m_readdatavalid[rd_pend_id_q] = 1'b1;
  end

  assign m_readdata = rd_pend_oor_q ? '0 : mem_readdata;
endmodule
